// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer, occupancy and status-flag controller for a FIFO of any depth >= 2.
// Define FIFO_PTR_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_ptr_ctrl #(
    parameter int MEMORY_DEPTH = 4,
    parameter int ADDRESS_SIZE = 2,
    parameter int AFULL_THR    = 3,
    parameter int AEMPTY_THR   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic                    err_clr,
    output logic [ADDRESS_SIZE-1:0] w_ptr,
    output logic [ADDRESS_SIZE-1:0] r_ptr,
    output logic                    wr_accept,
    output logic                    rd_accept,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int CW = ADDRESS_SIZE + 1;
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_SIZE-1:0] ONE_ADDR  = ADDRESS_SIZE'(1);
    localparam logic [CW-1:0]           DEPTH_C   = CW'(MEMORY_DEPTH);
    localparam logic [CW-1:0]           AFULL_C   = CW'(AFULL_THR);
    localparam logic [CW-1:0]           AEMPTY_C  = CW'(AEMPTY_THR);
    localparam logic [CW-1:0]           ONE_CNT   = CW'(1);

    logic [ADDRESS_SIZE-1:0] w_ptr_q, w_ptr_d;
    logic [ADDRESS_SIZE-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    // Handshake: a request (wr_en / rd_en) is taken in the cycle its accept
    // strobe is high; accepts depend only on the request and the current
    // registered occupancy, never on the opposite request.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
        wr_accept    = wr_en & ~full;
        rd_accept    = rd_en & ~empty;
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (wr_accept) begin
            w_ptr_d = (w_ptr_q == LAST_ADDR) ? '0 : w_ptr_q + ONE_ADDR;
        end
        if (rd_accept) begin
            r_ptr_d = (r_ptr_q == LAST_ADDR) ? '0 : r_ptr_q + ONE_ADDR;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

    assign w_ptr = w_ptr_q;
    assign r_ptr = r_ptr_q;
    assign count = count_q;

`ifdef FIFO_PTR_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q  & ~err_clr) | (wr_en & full);
        underflow_d = (underflow_q & ~err_clr) | (rd_en & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl (depth 5): directed scenarios plus random
// traffic against a queue-based occupancy model.
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int AFT   = 4;
  localparam int AET   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] w_ptr, r_ptr;
  logic          wr_accept, rd_accept;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue of write addresses; pointers as modulo counters.
  logic [AW-1:0] exp_q[$];
  int            m_wp = 0;
  int            m_rp = 0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  fifo_ptr_ctrl #(
    .MEMORY_DEPTH(DEPTH),
    .ADDRESS_SIZE(AW),
    .AFULL_THR(AFT),
    .AEMPTY_THR(AET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .err_clr(err_clr),
    .w_ptr(w_ptr),
    .r_ptr(r_ptr),
    .wr_accept(wr_accept),
    .rd_accept(rd_accept),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {w_ptr, r_ptr, count, full, empty, almost_full, almost_empty, overflow, underflow};

  function automatic logic [15:0] exp_vec();
    int occ;
    occ = exp_q.size();
    return {AW'(m_wp), AW'(m_rp), 4'(occ), occ == DEPTH, occ == 0, occ >= AFT, occ <= AET,
            m_ovf, m_unf};
  endfunction

  function automatic bit exp_wacc();
    return wr_en && (exp_q.size() != DEPTH);
  endfunction

  function automatic bit exp_racc();
    return rd_en && (exp_q.size() != 0);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_wp = 0;
    m_rp = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive request inputs shortly after the falling edge.
  task automatic set_inputs(input bit wr, input bit rd, input bit clr);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    err_clr = clr;
    #1;
  endtask

  // Advance one rising edge and step the model with the requests held on the inputs.
  task automatic tick();
    bit wa, ra, ov_ev, un_ev;
    wa = exp_wacc();
    ra = exp_racc();
    ov_ev = wr_en && (exp_q.size() == DEPTH);
    un_ev = rd_en && (exp_q.size() == 0);
    @(posedge clk);
    if (ra) begin
      void'(exp_q.pop_front());
      m_rp = (m_rp + 1) % DEPTH;
    end
    if (wa) begin
      exp_q.push_back(AW'(m_wp));
      m_wp = (m_wp + 1) % DEPTH;
    end
`ifdef FIFO_PTR_ERR_FLAGS_EN
    m_ovf = (m_ovf && !err_clr) || ov_ev;
    m_unf = (m_unf && !err_clr) || un_ev;
`else
    ov_ev = 1'b0;
    un_ev = 1'b0;
`endif
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #3;
    checks++;
    if (dut_vec !== 16'h0014) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_vec, 16'h0014);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [AW-1:0] wseq [5];
    wseq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < DEPTH; i++) begin
      set_inputs(1'b1, 1'b0, 1'b0);
      checks++;
      if (wr_accept !== 1'b1) begin
        errors++;
        $display("FAIL fill_wacc[%0d] got %b exp 1", i, wr_accept);
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec() || w_ptr !== wseq[i]) begin
        errors++;
        $display("FAIL fill[%0d] got %h exp %h (w_ptr exp %0d)", i, dut_vec, exp_vec(), wseq[i]);
      end
    end
  endtask

  task automatic test_overflow();
    set_inputs(1'b1, 1'b0, 1'b0);
    checks++;
    if (wr_accept !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wacc got %b exp 0", wr_accept);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        set_inputs(1'b0, 1'b0, 1'b0);
        tick();
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_hold[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    set_inputs(1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_set_wins got %h exp %h", dut_vec, exp_vec());
    end
    set_inputs(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_clear got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_simul_full();
    set_inputs(1'b1, 1'b1, 1'b0);
    checks++;
    if ({wr_accept, rd_accept} !== 2'b01) begin
      errors++;
      $display("FAIL full_both_acc got %b exp 01", {wr_accept, rd_accept});
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || count !== 4'd4) begin
      errors++;
      $display("FAIL full_both got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_drain();
    while (exp_q.size() > 0) begin
      set_inputs(1'b0, 1'b1, 1'b0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL drain got %h exp %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_underflow();
    logic [AW-1:0] rp0;
    rp0 = r_ptr;
    set_inputs(1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_accept !== 1'b0) begin
      errors++;
      $display("FAIL unf_racc got %b exp 0", rd_accept);
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || r_ptr !== rp0) begin
      errors++;
      $display("FAIL underflow got %h exp %h", dut_vec, exp_vec());
    end
    set_inputs(1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_simul_empty();
    logic [AW-1:0] rp0;
    rp0 = r_ptr;
    set_inputs(1'b1, 1'b1, 1'b0);
    checks++;
    if ({wr_accept, rd_accept} !== 2'b10) begin
      errors++;
      $display("FAIL empty_both_acc got %b exp 10", {wr_accept, rd_accept});
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || count !== 4'd1 || r_ptr !== rp0) begin
      errors++;
      $display("FAIL empty_both got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    while (exp_q.size() < 2) begin
      set_inputs(1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_inputs(1'b1, 1'b1, 1'b0);
      tick();
      checks++;
      if (dut_vec !== exp_vec() || count !== 4'd2) begin
        errors++;
        $display("FAIL b2b[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    while (exp_q.size() < 3) begin
      set_inputs(1'b1, 1'b0, 1'b0);
      tick();
    end
    set_inputs(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", dut_vec, exp_vec());
    end
    #1 rst = 1'b0;
    set_inputs(1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL after_reset got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit wr, rd, clr;
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 9) == 0);
      set_inputs(wr, rd, clr);
      checks++;
      if ({wr_accept, rd_accept} !== {exp_wacc(), exp_racc()}) begin
        errors++;
        $display("FAIL rand_acc[%0d] got %b exp %b", i, {wr_accept, rd_accept},
                 {exp_wacc(), exp_racc()});
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_state[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_simul_full();
    test_drain();
    test_underflow();
    test_simul_empty();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
